mc_key_extract: RTL
===================

Name: mc_key_extract

Overview:
- Parses a memcache binary-protocol request byte stream and extracts the key for the hash pipeline.
- Packs up to 12 key bytes into three 32-bit little-endian words (k0, k1, k2) and a byte count (key_length), then presents them to the lookup3 hash block with a one-cycle valid pulse.
- Skips extras and value bytes, and flags malformed or oversize frames.
- Sits between the network byte-stream receiver and lookup3.

Parameters:
- REQ_MAGIC, 8'h80: required value of header byte 0.
- MAX_KEY_BYTES, 12: longest key that is packed; legal range 1..12.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- din  in  8  stream byte.
- din_valid  in  1  din is valid this cycle; the block always accepts it.
- din_sof  in  1  qualifies din as byte 0 of a new frame; ignored unless din_valid.
- key_valid  out  1  one-cycle pulse; k0/k1/k2/key_length/opcode are valid.
- key_length  out  8  number of key bytes (1..12).
- k0  out  32  key bytes 0..3.
- k1  out  32  key bytes 4..7.
- k2  out  32  key bytes 8..11.
- opcode  out  8  header byte 1 of the frame that produced the key.
- err  out  1  one-cycle pulse; frame aborted (bad magic, truncated by sof, inconsistent lengths).
- key_too_long  out  1  one-cycle pulse; key length is 0 or greater than MAX_KEY_BYTES.

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs are 0.
  - State returns to IDLE; all counters are cleared.
  - A frame in progress is discarded with no err pulse.
- Header layout (24 bytes, multi-byte fields big-endian):
  - b0 magic; b1 opcode; b2-3 keylen; b4 extlen; b5 datatype; b6-7 vbucket; b8-11 bodylen; b12-23 opaque/CAS (ignored).
- States:
  - IDLE: wait for din_valid and din_sof.
    - If din equals REQ_MAGIC, go to HDR with hdr_cnt=1.
    - Otherwise pulse err and go to SKIP.
  - HDR: capture fields by hdr_cnt; hdr_cnt increments on each valid byte. On byte 23, check the frame:
    - keylen+extlen > bodylen (17-bit compare) → pulse err, go to SKIP with rem=bodylen.
    - keylen==0 or keylen>MAX_KEY_BYTES → pulse key_too_long, go to SKIP with rem=bodylen.
    - Otherwise go to EXTRAS, or directly to KEY if extlen==0.
    - If bodylen==0 and the frame reaches SKIP, go to IDLE instead.
  - EXTRAS: consume extlen bytes, then go to KEY.
  - KEY: write byte i into lane k[i/4][8*(i%4)+:8]. Lanes above keylen stay 0; the packing buffer is zeroed on entry to HDR. After the last key byte:
    - Register the outputs; key_valid is high in the following cycle (latency 1 cycle from the last key-byte accept).
    - Go to VALUE with rem = bodylen − extlen − keylen, or to IDLE if rem==0.
  - VALUE/SKIP: consume rem bytes (32-bit down-counter), then go to IDLE.
- din_sof in any state other than IDLE:
  - The current frame is aborted and err pulses. The exception is a sof arriving in the cycle right after normal completion, since the FSM is already in IDLE then.
  - The sof byte is processed as the IDLE case in the same cycle: magic check and go to HDR. This gives back-to-back frames with 0 idle cycles.
- Bytes with din_valid=0 are ignored, and gaps do not affect the result.
- Bytes arriving in IDLE without sof are dropped silently.
- key_length, k0..k2 and opcode hold their values after the key_valid pulse until the next key_valid. lookup3 samples them on the pulse.
- err and key_too_long are never asserted in the same cycle as key_valid. At most one of err and key_too_long is asserted per cycle.

Decomposition:
- Package memcache_pkg holds:
  - REQ_MAGIC.
  - Header byte offsets (OFF_OPCODE=1, OFF_KEYLEN=2, OFF_EXTLEN=4, OFF_BODYLEN=8, HDR_LEN=24).
  - State enum {IDLE, HDR, EXTRAS, KEY, VALUE, SKIP}.
- Sub-module mc_key_packer: byte index plus wr_en in; 96-bit packed key out; synchronous clear. It contains the lane decode only.

Test Plan:
- Key "hello" (keylen=5, extlen=0, bodylen=5), contiguous → key_valid 1 cycle after 'o'; key_length=5, k0=32'h6c6c6568, k1=32'h0000006f, k2=0, opcode=00.
- SET opcode 01, extlen=8, keylen=12 "abcdefghijkl", value 3 bytes, immediately followed by the "hello" frame → first pulse k0=64636261, k1=68676665, k2=6c6b6a69, key_length=12; second pulse matches scenario 1, with no err.
- First byte 0x81 with sof, then a valid "hello" frame → err pulses once with no key_valid; then the correct key_valid for "hello".
- keylen=13, bodylen=13 → key_too_long pulses once after header byte 23; no key_valid; the 13 bytes are skipped and the next frame parses.
- sof asserted at key byte 2 of "hello" → err pulse, and the new frame parses; separately, RST low mid-key → all outputs 0, and the next frame parses normally.
- "hello" frame with din_valid low on alternate cycles → identical outputs to scenario 1; key_valid 1 cycle after the last valid byte.

Source files
------------

// File: rtl/memcache_pkg.sv
// Shared constants, state encoding and output payload for the memcache key extractor.
package memcache_pkg;

    localparam logic [7:0]  REQ_MAGIC     = 8'h80;
    localparam int unsigned MAX_KEY_BYTES = 12;
    localparam int unsigned KEY_W         = 8 * MAX_KEY_BYTES;

    localparam int unsigned OFF_OPCODE    = 1;
    localparam int unsigned OFF_KEYLEN    = 2;
    localparam int unsigned OFF_EXTLEN    = 4;
    localparam int unsigned OFF_BODYLEN   = 8;
    localparam int unsigned HDR_LEN       = 24;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        EXTRAS,
        KEY,
        VALUE,
        SKIP
    } state_e;

    // Payload handed to lookup3 on the key_valid pulse.
    typedef struct packed {
        logic [7:0]  len;
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [7:0]  opcode;
    } key_out_t;

endpackage

// File: rtl/mc_key_packer.sv
// Little-endian key lane packer: byte idx lands in k[idx/4][8*(idx%4)+:8].
module mc_key_packer
    import memcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [3:0]       idx_i,
    input  logic [7:0]       byte_i,
    output logic [KEY_W-1:0] key_c
);

    logic [KEY_W-1:0] key_q;

    // Next packed value, visible in the same cycle as the byte being written.
    always_comb begin
        key_c = key_q;
        if (clr_i) begin
            key_c = '0;
        end else if (wr_en_i && (idx_i < 4'(MAX_KEY_BYTES))) begin
            key_c[{idx_i, 3'b000} +: 8] = byte_i;
        end
    end

    // Packing buffer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= '0;
        else        key_q <= key_c;
    end

endmodule

// File: rtl/mc_key_extract.sv
// Memcache binary request parser: extracts up to 12 key bytes for lookup3.
module mc_key_extract
    import memcache_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_sof,
    output logic        key_valid,
    output logic [7:0]  key_length,
    output logic [31:0] k0,
    output logic [31:0] k1,
    output logic [31:0] k2,
    output logic [7:0]  opcode,
    output logic        err,
    output logic        key_too_long
);

    state_e            state_q, state_d;
    logic [4:0]        hdr_cnt_q, hdr_cnt_d;
    logic [7:0]        opc_q, opc_d;
    logic [15:0]       keylen_q, keylen_d;
    logic [7:0]        extlen_q, extlen_d;
    logic [31:0]       bodylen_q, bodylen_d;
    logic [7:0]        ext_cnt_q, ext_cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       rem_q, rem_d;
    logic              lost_q, lost_d;
    key_out_t          out_q, out_d;
    logic              key_valid_q, key_valid_d;
    logic              err_q, err_d;
    logic              ktl_q, ktl_d;

    logic              pk_clr_c, pk_wr_c;
    logic [KEY_W-1:0]  key_c;
    logic [16:0]       len_sum_c;
    logic              bad_keylen_c;
    logic [31:0]       value_rem_c;

    // Packer controls kept outside the FSM block so its result can feed the output register.
    assign pk_clr_c = din_valid && din_sof && (din == REQ_MAGIC);
    assign pk_wr_c  = din_valid && !din_sof && (state_q == KEY);

    mc_key_packer u_packer (
        .clk     (CLK),
        .rst_n   (RST),
        .clr_i   (pk_clr_c),
        .wr_en_i (pk_wr_c),
        .idx_i   (idx_q),
        .byte_i  (din),
        .key_c   (key_c)
    );

    assign len_sum_c    = 17'(keylen_q) + 17'(extlen_q);
    assign bad_keylen_c = (keylen_q == 16'd0) || (keylen_q > 16'(MAX_KEY_BYTES));
    assign value_rem_c  = bodylen_q - 32'(extlen_q) - 32'(keylen_q);

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        opc_d       = opc_q;
        keylen_d    = keylen_q;
        extlen_d    = extlen_q;
        bodylen_d   = bodylen_q;
        ext_cnt_d   = ext_cnt_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        lost_d      = lost_q;
        out_d       = out_q;
        key_valid_d = 1'b0;
        err_d       = 1'b0;
        ktl_d       = 1'b0;

        if (din_valid) begin
            if (din_sof) begin
                // A frame already flagged by a bad magic is not reported a second time.
                if ((state_q != IDLE) && !((state_q == SKIP) && lost_q)) err_d = 1'b1;
                if (din == REQ_MAGIC) begin
                    state_d   = HDR;
                    hdr_cnt_d = 5'd1;
                    keylen_d  = '0;
                    extlen_d  = '0;
                    bodylen_d = '0;
                    lost_d    = 1'b0;
                end else begin
                    err_d     = 1'b1;
                    state_d   = SKIP;
                    rem_d     = '0;
                    lost_d    = 1'b1;
                end
            end else begin
                unique case (state_q)
                    IDLE: ;
                    HDR: begin
                        hdr_cnt_d = hdr_cnt_q + 5'd1;
                        if (hdr_cnt_q == 5'(OFF_OPCODE))     opc_d = din;
                        if (hdr_cnt_q == 5'(OFF_KEYLEN))     keylen_d[15:8] = din;
                        if (hdr_cnt_q == 5'(OFF_KEYLEN + 1)) keylen_d[7:0]  = din;
                        if (hdr_cnt_q == 5'(OFF_EXTLEN))     extlen_d = din;
                        if ((hdr_cnt_q >= 5'(OFF_BODYLEN)) && (hdr_cnt_q < 5'(OFF_BODYLEN + 4)))
                            bodylen_d = {bodylen_q[23:0], din};
                        if (hdr_cnt_q == 5'(HDR_LEN - 1)) begin
                            if ((32'(len_sum_c) > bodylen_q) || bad_keylen_c) begin
                                err_d   = !bad_keylen_c || (32'(len_sum_c) > bodylen_q);
                                ktl_d   = !err_d;
                                rem_d   = bodylen_q;
                                state_d = (bodylen_q == 32'd0) ? IDLE : SKIP;
                            end else begin
                                idx_d     = '0;
                                ext_cnt_d = extlen_q;
                                state_d   = (extlen_q == 8'd0) ? KEY : EXTRAS;
                            end
                        end
                    end
                    EXTRAS: begin
                        ext_cnt_d = ext_cnt_q - 8'd1;
                        if (ext_cnt_q <= 8'd1) state_d = KEY;
                    end
                    KEY: begin
                        if (idx_q == 4'(keylen_q - 16'd1)) begin
                            out_d.len    = 8'(keylen_q);
                            out_d.k0     = key_c[31:0];
                            out_d.k1     = key_c[63:32];
                            out_d.k2     = key_c[95:64];
                            out_d.opcode = opc_q;
                            key_valid_d  = 1'b1;
                            rem_d        = value_rem_c;
                            state_d      = (value_rem_c == 32'd0) ? IDLE : VALUE;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                    VALUE, SKIP: begin
                        // A frame that lost sync waits for the next sof.
                        if (!lost_q) begin
                            rem_d = rem_q - 32'd1;
                            if (rem_q <= 32'd1) state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= '0;
            opc_q       <= '0;
            keylen_q    <= '0;
            extlen_q    <= '0;
            bodylen_q   <= '0;
            ext_cnt_q   <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            lost_q      <= 1'b0;
            out_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ktl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            opc_q       <= opc_d;
            keylen_q    <= keylen_d;
            extlen_q    <= extlen_d;
            bodylen_q   <= bodylen_d;
            ext_cnt_q   <= ext_cnt_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            lost_q      <= lost_d;
            out_q       <= out_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            ktl_q       <= ktl_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_length   = out_q.len;
    assign k0           = out_q.k0;
    assign k1           = out_q.k1;
    assign k2           = out_q.k2;
    assign opcode       = out_q.opcode;
    assign err          = err_q;
    assign key_too_long = ktl_q;

endmodule
